// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N_REQ byte-stream requesters share one UART transmitter.
// A grant covers a whole packet and ends on the last byte, on a dropped request, or on an idle timeout.
module uart_tx_arbiter #(
   parameter int N_REQ       = 3,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req,
   input  logic [8*N_REQ-1:0]   in_data,
   input  logic [N_REQ-1:0]     in_write,
   input  logic [N_REQ-1:0]     in_last,
   output logic [N_REQ-1:0]     in_ready,
   output logic [N_REQ-1:0]     grant,
   input  logic                 uart_tx_ready,
   output logic [7:0]           uart_data,
   output logic                 uart_data_write,
   output logic                 timeout_pulse,
   output logic [7:0]           timeout_count
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t             state, state_n;
   logic [N_REQ-1:0]   grant_n;
   logic [IDX_W-1:0]   cur_idx, cur_n, last_idx, last_n, pick, cand;
   logic [CNT_W-1:0]   idle_cnt, cnt_n;
   logic               tpulse_n;
   logic [7:0]         tcount_n;
   logic               found;
   int                 sidx;
   logic [7:0]         cur_data;
   logic               cur_write, cur_last, cur_req;
   logic               accept;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Rotating search starting just after the last served requester.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      sidx  = 0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sidx = (int'(last_idx) + 1 + k) % N_REQ;
         cand = IDX_W'(sidx);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      cur_data  = 8'h00;
      cur_write = 1'b0;
      cur_last  = 1'b0;
      cur_req   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (cur_idx == IDX_W'(i)) begin
            cur_data  = in_data[8*i +: 8];
            cur_write = in_write[i];
            cur_last  = in_last[i];
            cur_req   = req[i];
         end
      end
   end

   assign accept          = (state == GRANT) && !rst && cur_write && uart_tx_ready;
   assign in_ready        = rst ? '0 : (grant & {N_REQ{uart_tx_ready}});
   assign uart_data       = ((state == GRANT) && !rst) ? cur_data : 8'h00;
   assign uart_data_write = accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         grant         <= '0;
         cur_idx       <= '0;
         last_idx      <= IDX_W'(N_REQ - 1);
         idle_cnt      <= '0;
         timeout_pulse <= 1'b0;
         timeout_count <= 8'h00;
      end else begin
         state         <= state_n;
         grant         <= grant_n;
         cur_idx       <= cur_n;
         last_idx      <= last_n;
         idle_cnt      <= cnt_n;
         timeout_pulse <= tpulse_n;
         timeout_count <= tcount_n;
      end
   end

   // Priority in GRANT: last-byte accept, then abort, then timeout.
   always_comb begin
      state_n  = state;
      grant_n  = grant;
      cur_n    = cur_idx;
      last_n   = last_idx;
      cnt_n    = idle_cnt;
      tpulse_n = 1'b0;
      tcount_n = timeout_count;
      case (state)
         IDLE: begin
            grant_n = '0;
            if (found) begin
               state_n       = GRANT;
               grant_n[pick] = 1'b1;
               cur_n         = pick;
               cnt_n         = '0;
            end
         end
         GRANT: begin
            if ((accept && cur_last) || !cur_req) begin
               state_n = GAP;
               grant_n = '0;
               last_n  = cur_idx;
            end else if (!accept && (idle_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
               state_n  = GAP;
               grant_n  = '0;
               last_n   = cur_idx;
               tpulse_n = 1'b1;
               tcount_n = sat_inc(timeout_count);
            end else if (accept) begin
               cnt_n = '0;
            end else begin
               cnt_n = idle_cnt + 1'b1;
            end
         end
         GAP: begin
            state_n = IDLE;
            grant_n = '0;
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of byte-stream requesters sharing one UART transmitter.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535, the number of idle cycles without an accepted byte after which a held grant is revoked.
REQ-003 SHALL have port clk, input, 1, clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port req, input, N_REQ, per-requester packet request (level).
REQ-006 SHALL have port in_data, input, 8*N_REQ, per-requester byte; requester i uses bits [8i+7:8i].
REQ-007 SHALL have port in_write, input, N_REQ, per-requester byte-valid strobe.
REQ-008 SHALL have port in_last, input, N_REQ, per-requester marker that the current byte is the last byte of the packet.
REQ-009 SHALL have port in_ready, output, N_REQ, per-requester ready; in_ready[i] = grant[i] & uart_tx_ready.
REQ-010 SHALL have port grant, output, N_REQ, one-hot or zero registered grant.
REQ-011 SHALL have port uart_tx_ready, input, 1, transmitter can accept a byte.
REQ-012 SHALL have port uart_data, output, 8, byte to transmitter.
REQ-013 SHALL have port uart_data_write, output, 1, byte strobe to transmitter.
REQ-014 SHALL have port timeout_pulse, output, 1, one-cycle pulse on grant revocation by timeout.
REQ-015 SHALL have port timeout_count, output, 8, saturating count of timeouts.

Function
REQ-016 SHALL implement FSM states IDLE, GRANT, GAP.
REQ-017 In IDLE with req!=0, SHALL select the first set req bit searching upward from (last_idx+1) mod N_REQ with wrap, register grant to that bit, store its index in cur_idx, and enter GRANT; grant is visible the cycle after req is sampled.
REQ-018 In IDLE with req==0, SHALL hold grant=0.
REQ-019 A byte SHALL be accepted when in_write[cur_idx] & in_ready[cur_idx] in GRANT.
REQ-020 uart_data SHALL equal in_data of cur_idx while in GRANT, else 0 (combinational, zero latency).
REQ-021 uart_data_write SHALL equal the accept condition of REQ-019, else 0; in_write from non-granted requesters SHALL be ignored.
REQ-022 On an accepted byte with in_last[cur_idx]=1, SHALL clear grant, set last_idx=cur_idx, and enter GAP.
REQ-023 In GRANT, if req[cur_idx] falls without a last byte, SHALL treat it as an abort: clear grant, set last_idx=cur_idx, enter GAP; no timeout is counted.
REQ-024 The idle counter SHALL clear on entry to GRANT and on every accepted byte, and increment each other GRANT cycle, including cycles with uart_tx_ready=0.
REQ-025 When the idle counter reaches TIMEOUT_CYC-1 in GRANT with no accept that cycle, SHALL clear grant, set last_idx=cur_idx, pulse timeout_pulse for 1 cycle, increment timeout_count (saturating at 255), and enter GAP.
REQ-026 If a last-byte accept and the timeout threshold coincide, the accept SHALL win; no timeout is counted.
REQ-027 GAP SHALL last exactly 1 cycle with grant=0, then return to IDLE; in total, a new grant is asserted no earlier than 2 cycles after the previous grant drops.
REQ-028 Requests SHALL not be queued; a requester whose req is low when sampled in IDLE is skipped.

Reset
REQ-029 While rst=1, SHALL set state=IDLE, grant=0, in_ready=0, uart_data=0, uart_data_write=0, timeout_pulse=0, timeout_count=0, idle counter=0, and last_idx=N_REQ-1 (first search starts at index 0).
REQ-030 Reset asserted mid-packet SHALL drop the grant the next cycle and discard packet state; no timeout is counted.

Verification
REQ-031 req=3'b111 held, each requester sends a 2-byte packet, uart_tx_ready=1 -> grants are 001, 010, 100, 001 in order, with 1 GAP cycle plus 1 IDLE cycle between them.
REQ-032 Granted requester 1 sends 0xA5, 0x5A (last) while requester 0 also strobes in_write -> uart_data shows only 0xA5 then 0x5A; requester 0's bytes never appear.
REQ-033 uart_tx_ready=0 for 3 cycles while in_write is held -> uart_data_write stays 0 for those 3 cycles, the byte is accepted on the first cycle ready=1, and there are no duplicates.
REQ-034 TIMEOUT_CYC=8, the granted requester stalls -> grant drops after 8 cycles, timeout_pulse pulses once, timeout_count=1, and the next requester is granted.
REQ-035 Requester 2 drops req mid-packet -> grant drops via GAP, timeout_count is unchanged, and the next grant goes to requester 0.
REQ-036 rst asserted during a byte stream -> all outputs return to reset values and the first grant after reset goes to the lowest set req bit.
